bbox_msg_reader: RTL and testbench
==================================

BBOX_MSG_READER -- requirements
Module: bbox_msg_reader

Interface
REQ-001 Parameter POLL_INTERVAL, default 1000: idle cycles between status polls when the FIFO holds fewer than 3 words.
REQ-002 Parameter MSG_ID, default 32'h00524242 ("RBB"): expected header word.
REQ-003 Parameter EXPECTED_ID, default 32'h1234EEE2: expected value at slave address 2.
REQ-004 clk  in  1  clock; reset reset_n, synchronous, active-low.
REQ-005 reset_n  in  1  synchronous active-low reset.
REQ-006 enable  in  1  permits polling; sampled only in POLL_WAIT.
REQ-007 m_chipselect  out  1  high when m_read or m_write is high.
REQ-008 m_read  out  1  single-cycle read strobe.
REQ-009 m_write  out  1  single-cycle write strobe.
REQ-010 m_address  out  3  slave word address: 0 status, 1 message, 2 ID.
REQ-011 m_writedata  out  32  write data.
REQ-012 m_readdata  in  32  slave read data, valid the cycle after m_read.
REQ-013 bb_valid  out  1  bounding-box output valid.
REQ-014 bb_ready  in  1  downstream accept.
REQ-015 bb_left, bb_top, bb_right, bb_bottom  out  11 each  box edges.
REQ-016 bb_none  out  1  high when bb_right < bb_left, meaning no red pixels.
REQ-017 id_ok  out  1  slave ID matched.
REQ-018 fault  out  1  slave ID mismatch; sticky until reset.
REQ-019 resync_count  out  8  number of header mismatches; saturates at 255.

Function
REQ-020 The FSM SHALL have these states: ID_RD, ID_WAIT, FAULT, POLL_WAIT, ST_RD, ST_WAIT, HDR_RD, HDR_WAIT, W1_RD, W1_WAIT, W2_RD, W2_WAIT, EMIT, FLUSH.
REQ-021 Each *_RD state SHALL last one cycle with m_read=1 and the listed address; the following *_WAIT state SHALL hold m_read=0 and capture m_readdata at the end of the cycle.
REQ-022 Consecutive reads SHALL always be separated by at least one cycle with m_read=0.
REQ-023 ID_RD SHALL use address 2. In ID_WAIT: a match sets id_ok=1 and enters POLL_WAIT with the counter loaded to 0; a mismatch sets fault=1 and enters FAULT.
REQ-024 FAULT SHALL be terminal until reset, with all bus strobes low.
REQ-025 POLL_WAIT SHALL decrement the poll counter each cycle and go to ST_RD when the counter is 0 and enable=1; the counter holds at 0 while enable=0.
REQ-026 ST_RD SHALL use address 0. In ST_WAIT: if m_readdata[15:8] >= 3, go to HDR_RD; otherwise load the counter with POLL_INTERVAL-1 and go to POLL_WAIT.
REQ-027 HDR_RD SHALL use address 1. In HDR_WAIT: a word equal to MSG_ID goes to W1_RD; any other value increments resync_count (saturating) and goes to FLUSH.
REQ-028 FLUSH SHALL last one cycle with m_write=1, address 0 and writedata 32'h00000010, then go to POLL_WAIT with the counter at 0.
REQ-029 W1_WAIT SHALL capture bb_left=readdata[26:16] and bb_top=readdata[10:0]; W2_WAIT SHALL capture bb_right=readdata[26:16] and bb_bottom=readdata[10:0], then go to EMIT.
REQ-030 In EMIT, bb_valid=1 and all bb_* outputs SHALL be held stable; on bb_valid&bb_ready the FSM goes to ST_RD. No bus access occurs while in EMIT.
REQ-031 bb_none SHALL be registered, computed in W2_WAIT from the captured values.
REQ-032 Register updates SHALL occur only in the *_WAIT state of the matching read.
REQ-033 m_writedata SHALL be 0 except in FLUSH; m_address SHALL be 0 when no strobe is active.

Reset
REQ-034 When reset_n=0 at a clock edge: state=ID_RD, m_read=m_write=m_chipselect=0, m_address=0, m_writedata=0, bb_valid=0, all bb_* outputs=0, bb_none=0, id_ok=0, fault=0, resync_count=0, poll counter=0.
REQ-035 Reset asserted mid-transaction SHALL abort it with no further strobes; after release the first access is ID_RD, on the cycle after reset_n goes high.

Verification
REQ-036 Release reset, slave ID=32'h1234EEE2, status words=3 -> reads on addresses 2, 0, 1, 1, 1 in that order; id_ok=1.
REQ-037 Slave ID=32'hDEADBEEF -> fault=1, id_ok=0, no further strobes for 1000 cycles.
REQ-038 Message "RBB", {5'b0,11'd100,5'b0,11'd50}, {5'b0,11'd300,5'b0,11'd200}, with bb_ready=0 for 10 cycles -> bb_valid held with left=100, top=50, right=300, bottom=200, bb_none=0; no bus activity until accept.
REQ-039 No-red frame, second and third words {639,479} and {0,0} -> bb_none=1.
REQ-040 Status words=2 with POLL_INTERVAL=8 -> successive status reads spaced exactly 8 cycles of POLL_WAIT apart; no message read.
REQ-041 Header 32'h00000007 -> resync_count=1, one write to address 0 with 32'h10, then a status read; 300 bad headers -> resync_count=255.

Source files
------------

// File: rtl/bbox_msg_reader.sv
// +----------------------------------------------------------------------+
// | bbox_msg_reader: polls a mailbox slave and emits bounding-box records |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module bbox_msg_reader #(
  parameter int          POLL_INTERVAL = 1000,
  parameter logic [31:0] MSG_ID        = 32'h00524242,
  parameter logic [31:0] EXPECTED_ID   = 32'h1234EEE2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic        m_chipselect,
  output logic        m_read,
  output logic        m_write,
  output logic [2:0]  m_address,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  output logic        bb_valid,
  input  logic        bb_ready,
  output logic [10:0] bb_left,
  output logic [10:0] bb_top,
  output logic [10:0] bb_right,
  output logic [10:0] bb_bottom,
  output logic        bb_none,
  output logic        id_ok,
  output logic        fault,
  output logic [7:0]  resync_count
);

  localparam int            c_CW     = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [c_CW-1:0] c_RELOAD = c_CW'(POLL_INTERVAL - 1);

  typedef enum logic [3:0] {
    ID_RD, ID_WAIT, FAULT, POLL_WAIT, ST_RD, ST_WAIT, HDR_RD, HDR_WAIT,
    W1_RD, W1_WAIT, W2_RD, W2_WAIT, EMIT, FLUSH
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_run;
  logic [c_CW-1:0] r_cnt;
  logic [10:0]     r_left, r_top, r_right, r_bottom;
  logic            r_none, r_id_ok, r_fault;
  logic [7:0]      r_resync;
  logic            w_rd, w_wr, w_valid;
  logic [2:0]      w_addr;
  logic [31:0]     w_wdata;

  // r_run keeps ID_RD silent during the reset cycle so the first strobe follows release
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ID_RD;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_run   <= 1'b1;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_rd    = 1'b0;
    w_wr    = 1'b0;
    w_addr  = 3'd0;
    w_wdata = 32'h0;
    w_valid = 1'b0;
    case (r_state)
      ID_RD: begin
        if (r_run) begin
          w_rd   = 1'b1;
          w_addr = 3'd2;
          w_next = ID_WAIT;
        end
      end
      ID_WAIT:   w_next = (m_readdata == EXPECTED_ID) ? POLL_WAIT : FAULT;
      FAULT:     w_next = FAULT;
      POLL_WAIT: if (r_cnt == '0 && enable) w_next = ST_RD;
      ST_RD: begin
        w_rd   = 1'b1;
        w_next = ST_WAIT;
      end
      ST_WAIT:   w_next = (m_readdata[15:8] >= 8'd3) ? HDR_RD : POLL_WAIT;
      HDR_RD: begin
        w_rd   = 1'b1;
        w_addr = 3'd1;
        w_next = HDR_WAIT;
      end
      HDR_WAIT:  w_next = (m_readdata == MSG_ID) ? W1_RD : FLUSH;
      W1_RD: begin
        w_rd   = 1'b1;
        w_addr = 3'd1;
        w_next = W1_WAIT;
      end
      W1_WAIT:   w_next = W2_RD;
      W2_RD: begin
        w_rd   = 1'b1;
        w_addr = 3'd1;
        w_next = W2_WAIT;
      end
      W2_WAIT:   w_next = EMIT;
      EMIT: begin
        w_valid = 1'b1;
        if (bb_ready) w_next = ST_RD;
      end
      FLUSH: begin
        w_wr    = 1'b1;
        w_wdata = 32'h0000_0010;
        w_next  = POLL_WAIT;
      end
      default:   w_next = ID_RD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_left   <= 11'd0;
      r_top    <= 11'd0;
      r_right  <= 11'd0;
      r_bottom <= 11'd0;
      r_none   <= 1'b0;
      r_id_ok  <= 1'b0;
      r_fault  <= 1'b0;
      r_resync <= 8'd0;
    end else begin
      case (r_state)
        ID_WAIT: begin
          if (m_readdata == EXPECTED_ID) begin
            r_id_ok <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_fault <= 1'b1;
          end
        end
        POLL_WAIT: if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        ST_WAIT:   if (m_readdata[15:8] < 8'd3) r_cnt <= c_RELOAD;
        HDR_WAIT: begin
          if (m_readdata != MSG_ID && r_resync != 8'hFF) r_resync <= r_resync + 1'b1;
        end
        W1_WAIT: begin
          r_left <= m_readdata[26:16];
          r_top  <= m_readdata[10:0];
        end
        W2_WAIT: begin
          r_right  <= m_readdata[26:16];
          r_bottom <= m_readdata[10:0];
          r_none   <= (m_readdata[26:16] < r_left);
        end
        FLUSH:   r_cnt <= '0;
        default: ;
      endcase
    end
  end

  assign m_read       = w_rd;
  assign m_write      = w_wr;
  assign m_chipselect = w_rd | w_wr;
  assign m_address    = w_addr;
  assign m_writedata  = w_wdata;
  assign bb_valid     = w_valid;
  assign bb_left      = r_left;
  assign bb_top       = r_top;
  assign bb_right     = r_right;
  assign bb_bottom    = r_bottom;
  assign bb_none      = r_none;
  assign id_ok        = r_id_ok;
  assign fault        = r_fault;
  assign resync_count = r_resync;

endmodule

`default_nettype wire

// File: tb/tb_bbox_msg_reader.sv
// Directed bench for bbox_msg_reader with a behavioural mailbox slave.
`default_nettype none

module tb_bbox_msg_reader;

  localparam logic [31:0] c_ID_GOOD = 32'h1234EEE2;
  localparam logic [31:0] c_MSG     = 32'h00524242;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        bb_ready = 1'b0;
  logic [31:0] m_readdata = 32'h0;
  logic        m_chipselect, m_read, m_write;
  logic [2:0]  m_address;
  logic [31:0] m_writedata;
  logic        bb_valid, bb_none, id_ok, fault;
  logic [10:0] bb_left, bb_top, bb_right, bb_bottom;
  logic [7:0]  resync_count;

  always #5 clk = ~clk;

  bbox_msg_reader #(.POLL_INTERVAL(8)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .m_chipselect(m_chipselect), .m_read(m_read), .m_write(m_write),
    .m_address(m_address), .m_writedata(m_writedata), .m_readdata(m_readdata),
    .bb_valid(bb_valid), .bb_ready(bb_ready),
    .bb_left(bb_left), .bb_top(bb_top), .bb_right(bb_right), .bb_bottom(bb_bottom),
    .bb_none(bb_none), .id_ok(id_ok), .fault(fault), .resync_count(resync_count)
  );

  typedef struct {
    int          cyc;
    bit          wr;
    logic [2:0]  addr;
    logic [31:0] data;
  } bus_t;

  bus_t        log_q[$];
  logic [31:0] msg_q[$];
  logic [31:0] slv_id = c_ID_GOOD;
  logic [31:0] slv_stat = 32'h300;
  int          cyc = 0;
  bit          prev_rd = 1'b0;
  int          b2b_err = 0;
  int          cs_err = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          rel;

  // Slave: read data appears the cycle after the strobe; every access is logged.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (m_read === 1'b1 && prev_rd) b2b_err++;
    prev_rd = (m_read === 1'b1);
    if (m_read === 1'b1 || m_write === 1'b1)
      log_q.push_back('{cyc, m_write, m_address, m_writedata});
    if (m_read === 1'b1) begin
      if (m_address == 3'd2)      m_readdata <= slv_id;
      else if (m_address == 3'd0) m_readdata <= slv_stat;
      else if (m_address == 3'd1) begin
        if (msg_q.size() > 0) m_readdata <= msg_q.pop_front();
        else                  m_readdata <= 32'h0;
      end else m_readdata <= 32'h0;
    end
  end

  always @(negedge clk) begin
    if (m_chipselect !== (m_read | m_write)) cs_err++;
    if (!m_read && !m_write && m_address !== 3'd0) cs_err++;
    if (!m_write && m_writedata !== 32'h0) cs_err++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget);
    int i = 0;
    while (bb_valid !== 1'b1 && i < budget) begin
      tick(1);
      i++;
    end
    chk("valid_timeout", 32'(bb_valid), 32'd1);
  endtask

  task automatic wait_log(input int n, input int budget);
    int i = 0;
    while (log_q.size() < n && i < budget) begin
      tick(1);
      i++;
    end
    chk("log_timeout", 32'(log_q.size() >= n), 32'd1);
  endtask

  initial begin
    int exp_addr[5] = '{2, 0, 1, 1, 1};
    enable  = 1'b1;
    reset_n = 1'b0;
    tick(3);
    chk("rst_read",   32'(m_read), 32'd0);
    chk("rst_cs",     32'(m_chipselect), 32'd0);
    chk("rst_valid",  32'(bb_valid), 32'd0);
    chk("rst_idok",   32'(id_ok), 32'd0);
    chk("rst_fault",  32'(fault), 32'd0);
    chk("rst_resync", 32'(resync_count), 32'd0);
    chk("rst_left",   32'(bb_left), 32'd0);
    chk("rst_none",   32'(bb_none), 32'd0);

    // Good ID, one complete message, then stall the consumer
    msg_q = '{c_MSG, {5'b0, 11'd100, 5'b0, 11'd50}, {5'b0, 11'd300, 5'b0, 11'd200}};
    log_q.delete();
    reset_n = 1'b1;
    rel = cyc;
    wait_valid(100);
    chk("seq_len", 32'(log_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < log_q.size(); i++) begin
      chk($sformatf("seq_addr%0d", i), 32'(log_q[i].addr), 32'(exp_addr[i]));
      chk($sformatf("seq_rd%0d", i), 32'(log_q[i].wr), 32'd0);
    end
    if (log_q.size() > 0) chk("first_rd_cycle", 32'(log_q[0].cyc), 32'(rel + 2));
    chk("id_ok", 32'(id_ok), 32'd1);
    chk("no_fault", 32'(fault), 32'd0);
    chk("left", 32'(bb_left), 32'd100);
    chk("top", 32'(bb_top), 32'd50);
    chk("right", 32'(bb_right), 32'd300);
    chk("bottom", 32'(bb_bottom), 32'd200);
    chk("none0", 32'(bb_none), 32'd0);
    tick(10);
    chk("stall_valid", 32'(bb_valid), 32'd1);
    chk("stall_bus", 32'(log_q.size()), 32'd5);
    chk("stall_left", 32'(bb_left), 32'd100);
    chk("stall_bottom", 32'(bb_bottom), 32'd200);

    // No-red frame
    msg_q = '{c_MSG, {5'b0, 11'd639, 5'b0, 11'd479}, 32'h0};
    bb_ready = 1'b1;
    tick(1);
    bb_ready = 1'b0;
    chk("accept_drop", 32'(bb_valid), 32'd0);
    wait_valid(50);
    chk("none1", 32'(bb_none), 32'd1);
    chk("nr_left", 32'(bb_left), 32'd639);
    chk("nr_top", 32'(bb_top), 32'd479);
    chk("nr_right", 32'(bb_right), 32'd0);
    chk("nr_bottom", 32'(bb_bottom), 32'd0);

    // Bad header -> flush, then an endless run of bad (zero) headers
    msg_q = '{32'h0000_0007};
    log_q.delete();
    bb_ready = 1'b1;
    tick(1);
    bb_ready = 1'b0;
    wait_log(4, 50);
    if (log_q.size() >= 4) begin
      chk("bh_st_addr", 32'(log_q[0].addr), 32'd0);
      chk("bh_hdr_addr", 32'(log_q[1].addr), 32'd1);
      chk("bh_flush_wr", 32'(log_q[2].wr), 32'd1);
      chk("bh_flush_addr", 32'(log_q[2].addr), 32'd0);
      chk("bh_flush_data", log_q[2].data, 32'h10);
      chk("bh_st2_rd", 32'(log_q[3].wr), 32'd0);
      chk("bh_st2_addr", 32'(log_q[3].addr), 32'd0);
      chk("bh_st2_gap", 32'(log_q[3].cyc - log_q[2].cyc), 32'd2);
    end
    chk("resync1", 32'(resync_count), 32'd1);
    tick(2000);
    chk("resync_sat", 32'(resync_count), 32'd255);

    // Fewer than 3 words: status reads only, 10 cycles apart
    slv_stat = 32'h200;
    tick(20);
    log_q.delete();
    tick(50);
    chk("poll_cnt", 32'(log_q.size() >= 4), 32'd1);
    for (int i = 1; i < log_q.size(); i++) begin
      chk($sformatf("poll_addr%0d", i), 32'(log_q[i].addr), 32'd0);
      chk($sformatf("poll_gap%0d", i), 32'(log_q[i].cyc - log_q[i-1].cyc), 32'd10);
    end

    enable = 1'b0;
    tick(15);
    log_q.delete();
    tick(30);
    chk("disable_bus", 32'(log_q.size()), 32'd0);
    enable = 1'b1;
    tick(15);
    chk("enable_bus", 32'(log_q.size() > 0), 32'd1);

    // Reset mid-flight, then a bad slave ID
    slv_id  = 32'hDEADBEEF;
    reset_n = 1'b0;
    tick(1);
    log_q.delete();
    tick(3);
    chk("rst_abort", 32'(log_q.size()), 32'd0);
    chk("rst_idok_clr", 32'(id_ok), 32'd0);
    chk("rst_resync_clr", 32'(resync_count), 32'd0);
    reset_n = 1'b1;
    rel = cyc;
    tick(5);
    chk("fault_set", 32'(fault), 32'd1);
    chk("fault_idok", 32'(id_ok), 32'd0);
    chk("fault_bus", 32'(log_q.size()), 32'd1);
    if (log_q.size() > 0) begin
      chk("fault_addr", 32'(log_q[0].addr), 32'd2);
      chk("rerst_first_cycle", 32'(log_q[0].cyc), 32'(rel + 2));
    end
    log_q.delete();
    tick(1000);
    chk("fault_quiet", 32'(log_q.size()), 32'd0);
    chk("fault_sticky", 32'(fault), 32'd1);

    chk("b2b_reads", 32'(b2b_err), 32'd0);
    chk("strobe_rules", 32'(cs_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
